// File: rtl/sar_search_n.sv
//------------------------------------------------------------------------------
// Module      : sar_search_n
// Description : Successive-approximation controller that drives a signed
//               less-than comparator and rebuilds its target one bit per step.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sar_search_n #(
  parameter int N       = 32,
  parameter int CMP_LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic [N-1:0] trial,
  input  logic         lt,
  output logic [N-1:0] result,
  output logic         done
);

  localparam int               c_kw        = $clog2(N);
  localparam logic [N-1:0]     c_msb       = {1'b1, {(N-1){1'b0}}};
  localparam logic [c_kw-1:0]  c_k_top     = c_kw'(N - 1);
  localparam logic [c_kw-1:0]  c_k_one     = c_kw'(1);
  localparam logic [c_kw-1:0]  c_k_zero    = '0;
  localparam logic [2:0]       c_wait_last = 3'(CMP_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TRY  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_code;
  logic [c_kw-1:0] r_k;
  logic [2:0]      r_wait;

  logic [c_kw-1:0] w_k_dec;
  logic [N-1:0]    w_code_dec;
  logic [N-1:0]    w_code_next;

  // Offset-binary code: flipping the MSB maps unsigned order onto signed order.
  assign trial   = {~r_code[N-1], r_code[N-2:0]};
  assign w_k_dec = r_k - c_k_one;

  always_comb begin
    w_code_dec = r_code;
    if (lt) begin
      w_code_dec[r_k] = 1'b0;
    end
    w_code_next          = w_code_dec;
    w_code_next[w_k_dec] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_code  <= c_msb;
      r_k     <= c_k_top;
      r_wait  <= 3'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_code  <= c_msb;
            r_k     <= c_k_top;
            r_wait  <= 3'd0;
            busy    <= 1'b1;
            r_state <= S_TRY;
          end
        end
        S_TRY: begin
          // lt only refers to the current trial once the comparator pipeline has filled.
          if (r_wait == c_wait_last) begin
            r_wait <= 3'd0;
            if (r_k == c_k_zero) begin
              r_code  <= w_code_dec;
              result  <= {~w_code_dec[N-1], w_code_dec[N-2:0]};
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_code <= w_code_next;
              r_k    <= w_k_dec;
            end
          end else begin
            r_wait <= r_wait + 3'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
